// File: rtl/det_pkg.sv
// Shared types and sizing for the determinant calculator's matrix entry path.
// Cell index is {row, col}, so a row occupies DIM_MAX consecutive cells.
package det_pkg;
    localparam int DIM_MAX = 8;
    localparam int ELEM_W  = 4;
    localparam int IDX_W   = 6;
    localparam int CELLS   = DIM_MAX * DIM_MAX;

    typedef enum logic [1:0] {
        ST_ENTRY = 2'd0,
        ST_LOAD  = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    function automatic logic [IDX_W-1:0] cell_idx(input logic [2:0] row, input logic [2:0] col);
        return {row, col};
    endfunction
endpackage

// File: rtl/matrix_store.sv
// 64-cell element register file with a per-cell valid bitmap, a written-cell
// counter and an N x N completeness flag for the top-left submatrix.
module matrix_store #(
    parameter int DW = 4
) (
    input  logic                      Clk,
    input  logic                      Reset_n,
    input  logic                      wr_en,
    input  logic [det_pkg::IDX_W-1:0] wr_idx,
    input  logic [DW-1:0]             wr_data,
    input  logic                      clr,
    input  logic [det_pkg::IDX_W-1:0] disp_idx,
    output logic [DW-1:0]             disp_data,
    input  logic [det_pkg::IDX_W-1:0] strm_idx,
    output logic [DW-1:0]             strm_data,
    input  logic [3:0]                chk_dim,
    output logic                      complete,
    output logic [6:0]                filled_count
);
    import det_pkg::*;

    logic [DW-1:0]    mem_reg [CELLS];
    logic [CELLS-1:0] valid_reg;
    logic [CELLS-1:0] valid_next;
    logic [CELLS-1:0] needed;
    logic [6:0]       count_reg;
    logic [6:0]       count_next;

    // Data is never reset: a Clear only masks cells through the bitmap.
    always_ff @(posedge Clk) begin
        if (wr_en) begin
            mem_reg[wr_idx] <= wr_data;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < CELLS; gi++) begin : g_cell
            localparam logic [3:0] CELL_ROW = 4'(gi / DIM_MAX);
            localparam logic [3:0] CELL_COL = 4'(gi % DIM_MAX);
            // A write in the same cycle as a clear survives the clear.
            assign valid_next[gi] = (wr_en && (wr_idx == IDX_W'(gi))) ? 1'b1
                                  : (clr ? 1'b0 : valid_reg[gi]);
            assign needed[gi] = (CELL_ROW < chk_dim) && (CELL_COL < chk_dim);
        end
    endgenerate

    always_comb begin
        count_next = clr ? 7'd0 : count_reg;
        if (wr_en && (clr || !valid_reg[wr_idx])) begin
            count_next = count_next + 7'd1;
        end
    end

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            valid_reg <= '0;
            count_reg <= '0;
        end else begin
            valid_reg <= valid_next;
            count_reg <= count_next;
        end
    end

    assign disp_data    = valid_reg[disp_idx] ? mem_reg[disp_idx] : '0;
    assign strm_data    = valid_reg[strm_idx] ? mem_reg[strm_idx] : '0;
    assign complete     = &(valid_reg | ~needed);
    assign filled_count = count_reg;
endmodule

// File: rtl/matrix_entry_ctrl.sv
// Matrix entry controller: captures cell writes, checks completeness on Start,
// streams the N x N submatrix row-major and waits for the engine to finish.
module matrix_entry_ctrl #(
    parameter int DIM_MAX = 8,
    parameter int ELEM_W  = 4
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic              Enter,
    input  logic              Start,
    input  logic              Clear,
    input  logic [2:0]        Row,
    input  logic [2:0]        Col,
    input  logic [ELEM_W-1:0] Value,
    input  logic [3:0]        Dim,
    output logic              Elem_valid,
    output logic [ELEM_W-1:0] Elem_data,
    output logic [2:0]        Elem_row,
    output logic [2:0]        Elem_col,
    output logic              Elem_last,
    input  logic              Elem_ready,
    input  logic              Comp_done,
    output logic [3:0]        Dim_q,
    output logic [5:0]        Disp_index,
    output logic [ELEM_W-1:0] Disp_value,
    output logic [6:0]        Filled_count,
    output logic              Err,
    output logic              q_Entry,
    output logic              q_Load,
    output logic              q_Wait,
    output logic              q_Done
);
    import det_pkg::state_t;
    import det_pkg::ST_ENTRY;
    import det_pkg::ST_LOAD;
    import det_pkg::ST_WAIT;
    import det_pkg::ST_DONE;
    import det_pkg::cell_idx;

    state_t            state_reg, state_next;
    logic [2:0]        row_reg, row_next;
    logic [2:0]        col_reg, col_next;
    logic              elem_valid_reg, elem_valid_next;
    logic              elem_last_reg, elem_last_next;
    logic [ELEM_W-1:0] elem_data_reg, elem_data_next;
    logic [3:0]        dim_q_reg, dim_q_next;
    logic              err_reg, err_next;

    logic [2:0]        nxt_row, nxt_col;
    logic [2:0]        last_idx;
    logic              in_entry, dim_legal, start_ok, xfer, complete;
    logic [ELEM_W-1:0] strm_data;

    assign in_entry  = (state_reg == ST_ENTRY);
    assign dim_legal = (Dim != 4'd0) && (Dim <= 4'(DIM_MAX));
    assign start_ok  = dim_legal && complete;
    assign xfer      = elem_valid_reg && Elem_ready;
    assign last_idx  = 3'(dim_q_reg - 4'd1);

    matrix_store #(
        .DW(ELEM_W)
    ) u_store (
        .Clk          (Clk),
        .Reset_n      (Reset_n),
        .wr_en        (in_entry && Enter),
        .wr_idx       (cell_idx(Row, Col)),
        .wr_data      (Value),
        .clr          (in_entry && Clear),
        .disp_idx     (cell_idx(Row, Col)),
        .disp_data    (Disp_value),
        .strm_idx     (cell_idx(nxt_row, nxt_col)),
        .strm_data    (strm_data),
        .chk_dim      (Dim),
        .complete     (complete),
        .filled_count (Filled_count)
    );

    // Pointer of the element presented after the next transfer; (0,0) outside LOAD
    // so the first element is already fetched when Start is accepted.
    always_comb begin
        nxt_row = 3'd0;
        nxt_col = 3'd0;
        if (state_reg == ST_LOAD) begin
            if (col_reg == last_idx) begin
                nxt_row = row_reg + 3'd1;
            end else begin
                nxt_row = row_reg;
                nxt_col = col_reg + 3'd1;
            end
        end
    end

    always_comb begin
        state_next      = state_reg;
        row_next        = row_reg;
        col_next        = col_reg;
        elem_valid_next = elem_valid_reg;
        elem_last_next  = elem_last_reg;
        elem_data_next  = elem_data_reg;
        dim_q_next      = dim_q_reg;
        err_next        = err_reg;
        case (state_reg)
            ST_ENTRY: begin
                // Any edit takes precedence over Start and clears the error flag.
                if (Enter || Clear) begin
                    err_next = 1'b0;
                end else if (Start) begin
                    if (start_ok) begin
                        state_next      = ST_LOAD;
                        dim_q_next      = Dim;
                        err_next        = 1'b0;
                        row_next        = 3'd0;
                        col_next        = 3'd0;
                        elem_valid_next = 1'b1;
                        elem_data_next  = strm_data;
                        elem_last_next  = (Dim == 4'd1);
                    end else begin
                        err_next = 1'b1;
                    end
                end
            end
            ST_LOAD: begin
                if (xfer) begin
                    if (elem_last_reg) begin
                        state_next      = ST_WAIT;
                        elem_valid_next = 1'b0;
                        elem_last_next  = 1'b0;
                    end else begin
                        row_next       = nxt_row;
                        col_next       = nxt_col;
                        elem_data_next = strm_data;
                        elem_last_next = (nxt_row == last_idx) && (nxt_col == last_idx);
                    end
                end
            end
            ST_WAIT: begin
                if (Comp_done) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                if (Start) begin
                    state_next = ST_ENTRY;
                end
            end
            default: state_next = ST_ENTRY;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            state_reg      <= ST_ENTRY;
            row_reg        <= '0;
            col_reg        <= '0;
            elem_valid_reg <= 1'b0;
            elem_last_reg  <= 1'b0;
            elem_data_reg  <= '0;
            dim_q_reg      <= '0;
            err_reg        <= 1'b0;
        end else begin
            state_reg      <= state_next;
            row_reg        <= row_next;
            col_reg        <= col_next;
            elem_valid_reg <= elem_valid_next;
            elem_last_reg  <= elem_last_next;
            elem_data_reg  <= elem_data_next;
            dim_q_reg      <= dim_q_next;
            err_reg        <= err_next;
        end
    end

    assign Elem_valid = elem_valid_reg;
    assign Elem_data  = elem_data_reg;
    assign Elem_row   = row_reg;
    assign Elem_col   = col_reg;
    assign Elem_last  = elem_last_reg;
    assign Dim_q      = dim_q_reg;
    assign Err        = err_reg;
    assign Disp_index = cell_idx(Row, Col);
    assign q_Entry    = (state_reg == ST_ENTRY);
    assign q_Load     = (state_reg == ST_LOAD);
    assign q_Wait     = (state_reg == ST_WAIT);
    assign q_Done     = (state_reg == ST_DONE);
endmodule

// File: tb/tb_matrix_entry_ctrl.sv
// Bench for matrix_entry_ctrl: a cell-array/element-counter model checked every
// cycle, plus directed scenarios with literal expectations.
module tb_matrix_entry_ctrl;
    logic       Clk = 1'b0;
    logic       Reset_n = 1'b0;
    logic       Enter = 1'b0, Start = 1'b0, Clear = 1'b0;
    logic [2:0] Row = 3'd0, Col = 3'd0;
    logic [3:0] Value = 4'd0, Dim = 4'd0;
    logic       Elem_ready = 1'b1, Comp_done = 1'b0;
    logic       Elem_valid, Elem_last, Err, q_Entry, q_Load, q_Wait, q_Done;
    logic [3:0] Elem_data, Dim_q, Disp_value;
    logic [2:0] Elem_row, Elem_col;
    logic [5:0] Disp_index;
    logic [6:0] Filled_count;

    always #5 Clk = ~Clk;

    matrix_entry_ctrl #(.DIM_MAX(8), .ELEM_W(4)) dut (
        .Clk(Clk), .Reset_n(Reset_n), .Enter(Enter), .Start(Start), .Clear(Clear),
        .Row(Row), .Col(Col), .Value(Value), .Dim(Dim),
        .Elem_valid(Elem_valid), .Elem_data(Elem_data), .Elem_row(Elem_row),
        .Elem_col(Elem_col), .Elem_last(Elem_last), .Elem_ready(Elem_ready),
        .Comp_done(Comp_done), .Dim_q(Dim_q), .Disp_index(Disp_index),
        .Disp_value(Disp_value), .Filled_count(Filled_count), .Err(Err),
        .q_Entry(q_Entry), .q_Load(q_Load), .q_Wait(q_Wait), .q_Done(q_Done)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: 0=ENTRY 1=LOAD 2=WAIT 3=DONE; m_k is the index of the element on offer.
    int m_store [8][8];
    bit m_vld   [8][8];
    int m_state = 0;
    bit m_err = 1'b0;
    int m_dimq = 0;
    int m_k = 0;
    bit m_rst = 1'b0;
    int cyc = 0;
    int xq_data[$];
    bit xq_last[$];
    int xq_cyc[$];

    function automatic bit m_complete(input int n);
        for (int r = 0; r < n; r++)
            for (int c = 0; c < n; c++)
                if (!m_vld[r][c]) return 1'b0;
        return 1'b1;
    endfunction

    function automatic int m_filled();
        int cnt = 0;
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++)
                if (m_vld[r][c]) cnt++;
        return cnt;
    endfunction

    always @(posedge Clk) begin
        cyc++;
        if (!Reset_n) begin
            m_state = 0; m_err = 1'b0; m_dimq = 0; m_k = 0; m_rst = 1'b1;
            for (int r = 0; r < 8; r++)
                for (int c = 0; c < 8; c++) m_vld[r][c] = 1'b0;
        end else begin
            m_rst = 1'b0;
            case (m_state)
                0: begin
                    if (Clear)
                        for (int r = 0; r < 8; r++)
                            for (int c = 0; c < 8; c++) m_vld[r][c] = 1'b0;
                    if (Enter) begin
                        m_store[Row][Col] = int'(Value);
                        m_vld[Row][Col] = 1'b1;
                    end
                    if (Enter || Clear) m_err = 1'b0;
                    else if (Start) begin
                        if (Dim >= 1 && Dim <= 8 && m_complete(int'(Dim))) begin
                            m_state = 1; m_dimq = int'(Dim); m_k = 0; m_err = 1'b0;
                        end else m_err = 1'b1;
                    end
                end
                1: if (Elem_ready) begin
                    if (m_k == m_dimq * m_dimq - 1) m_state = 2;
                    else m_k++;
                end
                2: if (Comp_done) m_state = 3;
                default: if (Start) m_state = 0;
            endcase
        end
        #1;
        chk("q_Entry", 32'(q_Entry), 32'(m_state == 0));
        chk("q_Load", 32'(q_Load), 32'(m_state == 1));
        chk("q_Wait", 32'(q_Wait), 32'(m_state == 2));
        chk("q_Done", 32'(q_Done), 32'(m_state == 3));
        chk("Elem_valid", 32'(Elem_valid), 32'(m_state == 1));
        chk("Elem_last", 32'(Elem_last), 32'(m_state == 1 && m_k == m_dimq * m_dimq - 1));
        chk("Dim_q", 32'(Dim_q), m_dimq);
        chk("Err", 32'(Err), 32'(m_err));
        chk("Filled_count", 32'(Filled_count), m_filled());
        chk("Disp_index", 32'(Disp_index), int'(Row) * 8 + int'(Col));
        chk("Disp_value", 32'(Disp_value), m_vld[Row][Col] ? m_store[Row][Col] : 0);
        if (m_state == 1) begin
            chk("Elem_row", 32'(Elem_row), m_k / m_dimq);
            chk("Elem_col", 32'(Elem_col), m_k % m_dimq);
            chk("Elem_data", 32'(Elem_data), m_store[m_k / m_dimq][m_k % m_dimq]);
        end
        if (m_rst) begin
            chk("rst_Elem_row", 32'(Elem_row), 0);
            chk("rst_Elem_col", 32'(Elem_col), 0);
            chk("rst_Elem_data", 32'(Elem_data), 0);
        end
    end

    // Transfers are sampled just before the edge that performs them.
    always @(negedge Clk) begin
        #4;
        if (Reset_n && Elem_valid && Elem_ready) begin
            xq_data.push_back(int'(Elem_data));
            xq_last.push_back(Elem_last);
            xq_cyc.push_back(cyc);
        end
    end

    task automatic wr(input int r, input int c, input int v);
        Row = 3'(r); Col = 3'(c); Value = 4'(v); Enter = 1'b1;
        @(negedge Clk);
        Enter = 1'b0;
        $display("write (%0d,%0d)=%0d filled=%0d", r, c, v, Filled_count);
    endtask

    task automatic start(input int d);
        Dim = 4'(d); Start = 1'b1;
        @(negedge Clk);
        Start = 1'b0;
        $display("start dim=%0d -> entry=%0b load=%0b done=%0b err=%0b", d, q_Entry, q_Load, q_Done, Err);
    endtask

    task automatic pulse_done();
        Comp_done = 1'b1;
        @(negedge Clk);
        Comp_done = 1'b0;
        $display("comp_done -> q_Done=%0b", q_Done);
    endtask

    task automatic do_clear();
        Clear = 1'b1;
        @(negedge Clk);
        Clear = 1'b0;
        $display("clear filled=%0d", Filled_count);
    endtask

    task automatic wait_for_wait(output int n);
        n = 0;
        while (!q_Wait && n < 50) begin
            @(negedge Clk);
            n++;
        end
        chk("wait_reached", 32'(q_Wait), 1);
    endtask

    int n;
    int exp_n2[4] = '{1, 2, 3, 4};

    initial begin
        repeat (3) @(negedge Clk);
        Reset_n = 1'b1;
        @(negedge Clk);
        chk("rst_q_Entry", 32'(q_Entry), 1);
        chk("rst_filled", 32'(Filled_count), 0);

        // N=2 stream with ready held high
        wr(0, 0, 1); wr(0, 1, 2); wr(1, 0, 3); wr(1, 1, 4);
        xq_data.delete(); xq_last.delete(); xq_cyc.delete();
        start(2);
        chk("n2_first_data", 32'(Elem_data), 1);
        wait_for_wait(n);
        chk("n2_load_cycles", n, 4);
        chk("n2_xfers", xq_data.size(), 4);
        for (int i = 0; i < 4 && i < xq_data.size(); i++) begin
            chk("n2_data", xq_data[i], exp_n2[i]);
            chk("n2_last", 32'(xq_last[i]), 32'(i == 3));
        end
        if (xq_cyc.size() == 4) chk("n2_consecutive", xq_cyc[3] - xq_cyc[0], 3);
        chk("wait_valid_low", 32'(Elem_valid), 0);
        pulse_done();
        chk("done_entered", 32'(q_Done), 1);
        start(0);
        chk("ack_entry", 32'(q_Entry), 1);
        Row = 3'd1; Col = 3'd1; #1;
        chk("retained_11", 32'(Disp_value), 4);

        // N=3 incomplete, then completed
        wr(0, 2, 5); wr(1, 2, 6); wr(2, 0, 7); wr(2, 1, 8);
        start(3);
        chk("n3_err", 32'(Err), 1);
        chk("n3_stay", 32'(q_Entry), 1);
        wr(2, 2, 7);
        chk("n3_err_cleared", 32'(Err), 0);
        start(3);
        chk("n3_accepted", 32'(q_Load), 1);
        repeat (4) @(negedge Clk);
        chk("n3_mid_row", 32'(Elem_row), 1);
        chk("n3_mid_col", 32'(Elem_col), 1);
        Reset_n = 1'b0;
        @(negedge Clk);
        Reset_n = 1'b1;
        chk("midrst_entry", 32'(q_Entry), 1);
        chk("midrst_valid", 32'(Elem_valid), 0);
        chk("midrst_filled", 32'(Filled_count), 0);

        // Backpressure on element (0,1)
        wr(0, 0, 1); wr(0, 1, 2); wr(1, 0, 3); wr(1, 1, 4);
        xq_data.delete(); xq_last.delete(); xq_cyc.delete();
        start(2);
        @(negedge Clk);
        Elem_ready = 1'b0;
        repeat (3) begin
            @(negedge Clk);
            chk("bp_data", 32'(Elem_data), 2);
            chk("bp_row", 32'(Elem_row), 0);
            chk("bp_col", 32'(Elem_col), 1);
            chk("bp_valid", 32'(Elem_valid), 1);
        end
        Elem_ready = 1'b1;
        wait_for_wait(n);
        chk("bp_xfers", xq_data.size(), 4);
        pulse_done();
        start(0);

        // Rewrite and Clear+Enter
        do_clear();
        chk("clear_filled", 32'(Filled_count), 0);
        wr(1, 1, 5);
        chk("rewrite_first", 32'(Filled_count), 1);
        wr(1, 1, 9);
        chk("rewrite_filled", 32'(Filled_count), 1);
        chk("rewrite_value", 32'(Disp_value), 9);
        Clear = 1'b1;
        wr(0, 0, 6);
        Clear = 1'b0;
        chk("clr_enter_filled", 32'(Filled_count), 1);
        chk("clr_enter_value", 32'(Disp_value), 6);
        Row = 3'd1; Col = 3'd1; #1;
        chk("masked_value", 32'(Disp_value), 0);

        // Illegal dimensions
        start(0);
        chk("dim0_err", 32'(Err), 1);
        chk("dim0_stay", 32'(q_Entry), 1);
        wr(3, 3, 1);
        chk("dim_err_cleared", 32'(Err), 0);
        chk("disp_index_33", 32'(Disp_index), 27);
        start(9);
        chk("dim9_err", 32'(Err), 1);
        chk("dim9_stay", 32'(q_Entry), 1);

        // N=1 run, Comp_done ignored outside WAIT
        pulse_done();
        chk("done_ignored_entry", 32'(q_Entry), 1);
        start(1);
        chk("n1_last", 32'(Elem_last), 1);
        wait_for_wait(n);
        pulse_done();
        chk("n1_done", 32'(q_Done), 1);
        pulse_done();
        chk("done_hold", 32'(q_Done), 1);
        start(5);
        chk("ack2_entry", 32'(q_Entry), 1);
        chk("dimq_held", 32'(Dim_q), 1);
        Row = 3'd0; Col = 3'd0; #1;
        chk("retained_00", 32'(Disp_value), 6);

        repeat (2) @(negedge Clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end
endmodule
